// File: rtl/seg_pkg.sv
// Shared segment encodings and helpers for the multiplexed seven-segment driver.
package seg_pkg;

    localparam int         MAX_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_DASH   = 7'b1111110;

    // Active-low cathodes, bit6=a ... bit0=g; non-decimal codes render blank.
    function automatic logic [6:0] seg_cath(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'd0:    pat = 7'b0000001;
            4'd1:    pat = 7'b1001111;
            4'd2:    pat = 7'b0010010;
            4'd3:    pat = 7'b0000110;
            4'd4:    pat = 7'b1001100;
            4'd5:    pat = 7'b0100100;
            4'd6:    pat = 7'b0100000;
            4'd7:    pat = 7'b0001111;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0001100;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_bcd_conv.sv
// Sequential double-dabble: one add-3/shift iteration per cycle, VAL_W cycles per value.
// The bcd/ovf outputs are the display register and only change when a conversion completes.
module seg_bcd_conv
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int VAL_W  = 14
) (
    input  logic                  ck,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [VAL_W-1:0]      bin,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int          BCD_W   = 4 * DIGITS;
    localparam int          CNT_W   = $clog2(VAL_W + 1);
    localparam logic [31:0] MAX_VAL = pow10(DIGITS) - 32'd1;

    logic                    busy_q;
    logic                    ovf_w_q;
    logic                    ovf_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [BCD_W-1:0]        bcd_w_q;
    logic [VAL_W-1:0]        bin_w_q;
    logic [BCD_W-1:0]        bcd_q;

    logic [BCD_W-1:0]        adj_d;
    logic [BCD_W+VAL_W-1:0]  shift_d;

    always_comb begin
        adj_d = bcd_w_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_w_q[4*i +: 4] >= 4'd5) begin
                adj_d[4*i +: 4] = bcd_w_q[4*i +: 4] + 4'd3;
            end
        end
        shift_d = {adj_d, bin_w_q} << 1;
    end

    // The final iteration's result goes straight to the display register on the edge busy drops.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            ovf_w_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else if (!busy_q) begin
            if (start) begin
                busy_q  <= 1'b1;
                bin_w_q <= bin;
                bcd_w_q <= '0;
                cnt_q   <= '0;
                ovf_w_q <= (32'(bin) > MAX_VAL);
            end
        end else begin
            {bcd_w_q, bin_w_q} <= shift_d;
            cnt_q              <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(VAL_W - 1)) begin
                busy_q <= 1'b0;
                bcd_q  <= shift_d[BCD_W+VAL_W-1 -: BCD_W];
                ovf_q  <= ovf_w_q;
            end
        end
    end

    assign busy = busy_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/seg_mux.sv
// Multiplexed active-low seven-segment driver: BCD conversion, digit scan and output registers.
// Optional feature macro SEG_LZB_EN enables leading-zero blanking (digit 0 always shown).
module seg_mux
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int VAL_W       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic [VAL_W-1:0] num,
    input  logic             load,
    output logic             busy,
    output logic [6:0]       dig,
    output logic [7:0]       an
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [4*DIGITS-1:0] bcd;
    logic                ovf;

    logic [PRE_W-1:0]    pre_q;
    logic [2:0]          idx_q;
    logic [6:0]          dig_q;
    logic [7:0]          an_q;

    logic [DIGITS-1:0]   keep;
    logic [3:0]          nib;
    logic                lit;
    logic [6:0]          dig_d;
    logic [7:0]          an_d;
`ifdef SEG_LZB_EN
    logic                seen;
`endif

    seg_bcd_conv #(
        .DIGITS (DIGITS),
        .VAL_W  (VAL_W)
    ) u_conv (
        .ck    (ck),
        .rst_n (rst_n),
        .start (load),
        .bin   (num),
        .busy  (busy),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    // keep[i] marks digits that are lit; blanking walks down from the most significant digit.
    always_comb begin
        keep = '1;
`ifdef SEG_LZB_EN
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen    = seen | (bcd[4*i +: 4] != 4'd0);
            keep[i] = seen | (i == 0);
        end
`endif
    end

    always_comb begin
        nib = 4'd0;
        lit = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                nib = bcd[4*i +: 4];
                lit = keep[i];
            end
        end

        an_d        = 8'hFF;
        an_d[idx_q] = 1'b0;

        if (ovf) begin
            dig_d = SEG_DASH;
        end else if (!lit) begin
            dig_d = SEG_BLANK;
        end else begin
            dig_d = seg_cath(nib);
        end
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= 3'd0;
            dig_q <= SEG_BLANK;
            an_q  <= 8'hFF;
        end else begin
            if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
                pre_q <= '0;
                idx_q <= (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
            dig_q <= dig_d;
            an_q  <= an_d;
        end
    end

    assign dig = dig_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg_mux.sv
// Directed bench for seg_mux with DIGITS=4, VAL_W=14, REFRESH_DIV=4 (honours SEG_LZB_EN).
module tb_seg_mux;

    localparam int DIGITS      = 4;
    localparam int VAL_W       = 14;
    localparam int REFRESH_DIV = 4;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0001100;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b1111110;
`ifdef SEG_LZB_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic             ck    = 1'b0;
    logic             rst_n = 1'b0;
    logic             load  = 1'b0;
    logic [VAL_W-1:0] num   = '0;
    logic             busy;
    logic [6:0]       dig;
    logic [7:0]       an;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [VAL_W-1:0] num;
        logic [3:0][6:0]  exp;
    } vec_t;

    vec_t vecs[8];

    seg_mux #(
        .DIGITS      (DIGITS),
        .VAL_W       (VAL_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .num   (num),
        .load  (load),
        .busy  (busy),
        .dig   (dig),
        .an    (an)
    );

    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_load(input logic [VAL_W-1:0] v);
        num  = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check({name, " busy cycles"}, n, exp_cycles);
    endtask

    // One full frame; the digit expected is chosen by whichever anode is active.
    task automatic scan_check(input string name, input logic [3:0][6:0] exp);
        tick();
        for (int k = 0; k < 4 * REFRESH_DIV; k++) begin
            int idx;
            case (an)
                8'hFE:   idx = 0;
                8'hFD:   idx = 1;
                8'hFB:   idx = 2;
                8'hF7:   idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                check($sformatf("%s anode k%0d", name, k), an, 8'hFE);
            end else begin
                check($sformatf("%s d%0d", name, idx), dig, exp[idx]);
            end
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{14'd1234,  {S1, S2, S3, S4}};
        vecs[1] = '{14'd9999,  {S9, S9, S9, S9}};
        vecs[2] = '{14'd10000, {SD, SD, SD, SD}};
        vecs[3] = '{14'd7,     {LZ, LZ, LZ, S7}};
        vecs[4] = '{14'd5,     {LZ, LZ, LZ, S5}};
        vecs[5] = '{14'd0,     {LZ, LZ, LZ, S0}};
        vecs[6] = '{14'd8060,  {S8, S0, S6, S0}};
        vecs[7] = '{14'd16383, {SD, SD, SD, SD}};

        // Reset state and scan rotation straight after release
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset dig", dig, SB);
        check("reset an", an, 8'hFF);
        check("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();
        check("release an", an, 8'hFE);
        check("release dig", dig, S0);
        for (int k = 1; k < 4 * REFRESH_DIV; k++) begin
            logic [7:0] e;
            tick();
            e = 8'hFF;
            e[k / REFRESH_DIV] = 1'b0;
            check($sformatf("rotation k%0d", k), an, e);
        end

        // Table of captured values
        for (int v = 0; v < 8; v++) begin
            do_load(vecs[v].num);
            wait_done($sformatf("vec %0d", vecs[v].num), VAL_W);
            scan_check($sformatf("vec %0d", vecs[v].num), vecs[v].exp);
        end

        // load while busy is dropped: 42 then 99 five cycles later
        do_load(14'd42);
        repeat (4) tick();
        num  = 14'd99;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("99 while busy", busy, 1'b1);
        wait_done("42 after 99", VAL_W - 5);
        scan_check("show 42", {LZ, LZ, S4, S2});

        // load on the edge busy falls is ignored, the next cycle is accepted
        do_load(14'd5);
        repeat (VAL_W - 1) tick();
        check("busy before fall", busy, 1'b1);
        num  = 14'd7;
        load = 1'b1;
        tick();
        check("load at fall ignored", busy, 1'b0);
        tick();
        load = 1'b0;
        check("load after fall taken", busy, 1'b1);
        wait_done("7 after fall", VAL_W);
        scan_check("show 7", {LZ, LZ, LZ, S7});

        // Reset in the middle of a conversion
        do_load(14'd5678);
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset busy", busy, 1'b0);
        check("midreset an", an, 8'hFF);
        tick();
        check("midreset release an", an, 8'hFE);
        check("midreset release dig", dig, S0);
        scan_check("midreset zero", {LZ, LZ, LZ, S0});
        repeat (10) tick();
        check("midreset no late busy", busy, 1'b0);
        scan_check("midreset no stale", {LZ, LZ, LZ, S0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
